// File: rtl/telemetry_framer_if.sv
// Byte-wide start/busy/done handshake between the telemetry framer and uart_tx.
// The framer is the master; the UART transmitter is the slave.
interface telemetry_framer_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/telemetry_framer.sv
// Packs roll/pitch/yaw into a 10-byte frame (headers, seq, payload, xor chk)
// and streams it to uart_tx; samples arriving mid-frame are counted as drops.
module telemetry_framer #(
    parameter logic [7:0] HEADER0 = 8'hDE,
    parameter logic [7:0] HEADER1 = 8'hAD
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_valid,
    input  logic signed [15:0]  roll_in,
    input  logic signed [15:0]  pitch_in,
    input  logic signed [15:0]  yaw_in,
    telemetry_framer_if.master  uart,
    output logic                frame_busy,
    output logic                frame_sent,
    output logic [7:0]          drop_count
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'd9;

    state_t      state;
    logic [3:0]  idx;
    logic [7:0]  seq;
    logic [7:0]  seq_q;
    logic [15:0] roll_q;
    logic [15:0] pitch_q;
    logic [15:0] yaw_q;
    logic [7:0]  chk;
    logic [7:0]  cur_byte;

    always_comb begin
        chk = seq_q
            ^ roll_q[15:8]  ^ roll_q[7:0]
            ^ pitch_q[15:8] ^ pitch_q[7:0]
            ^ yaw_q[15:8]   ^ yaw_q[7:0];
    end

    always_comb begin
        cur_byte = chk;
        case (idx)
            4'd0:    cur_byte = HEADER0;
            4'd1:    cur_byte = HEADER1;
            4'd2:    cur_byte = seq_q;
            4'd3:    cur_byte = roll_q[15:8];
            4'd4:    cur_byte = roll_q[7:0];
            4'd5:    cur_byte = pitch_q[15:8];
            4'd6:    cur_byte = pitch_q[7:0];
            4'd7:    cur_byte = yaw_q[15:8];
            4'd8:    cur_byte = yaw_q[7:0];
            default: cur_byte = chk;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= 4'd0;
            seq           <= 8'h00;
            seq_q         <= 8'h00;
            roll_q        <= 16'h0000;
            pitch_q       <= 16'h0000;
            yaw_q         <= 16'h0000;
            uart.tx_start <= 1'b0;
            uart.tx_data  <= 8'h00;
            frame_busy    <= 1'b0;
            frame_sent    <= 1'b0;
        end else begin
            uart.tx_start <= 1'b0;
            frame_sent    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (sample_valid) begin
                        roll_q     <= roll_in;
                        pitch_q    <= pitch_in;
                        yaw_q      <= yaw_in;
                        seq_q      <= seq;
                        idx        <= 4'd0;
                        state      <= SEND;
                        frame_busy <= 1'b1;
                    end
                end
                SEND: begin
                    if (!uart.tx_busy) begin
                        uart.tx_start <= 1'b1;
                        uart.tx_data  <= cur_byte;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    // tx_done is only meaningful while a byte is outstanding
                    if (uart.tx_done) begin
                        if (idx == LAST_IDX) begin
                            frame_sent <= 1'b1;
                            frame_busy <= 1'b0;
                            seq        <= seq + 8'd1;
                            state      <= IDLE;
                        end else begin
                            idx   <= idx + 4'd1;
                            state <= SEND;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    frame_busy <= 1'b0;
                end
            endcase
        end
    end

    // A sample is dropped whenever the FSM is not idle, including the
    // cycle that retires the final byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= 8'h00;
        end else if (sample_valid && state != IDLE && drop_count != 8'hFF) begin
            drop_count <= drop_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_telemetry_framer.sv
// Directed bench for telemetry_framer with a simple uart_tx responder.
// Frames are captured byte by byte and compared to hand-computed vectors.
module tb_telemetry_framer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_valid;
    logic [15:0] roll;
    logic [15:0] pitch;
    logic [15:0] yaw;
    logic        frame_busy;
    logic        frame_sent;
    logic [7:0]  drop_count;

    logic m_busy    = 1'b0;
    logic m_done    = 1'b0;
    logic hold_busy = 1'b0;
    logic spur_done = 1'b0;
    logic prev_start = 1'b0;

    int done_dly  = 20;
    int checks    = 0;
    int errors    = 0;
    int start_cnt = 0;
    int dbl_start = 0;
    int sent_cnt  = 0;

    logic [7:0] cap_q [$];

    always #5 clk = ~clk;

    telemetry_framer_if uart ();

    assign uart.tx_busy = m_busy | hold_busy;
    assign uart.tx_done = m_done | spur_done;

    telemetry_framer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .roll_in      (roll),
        .pitch_in     (pitch),
        .yaw_in       (yaw),
        .uart         (uart),
        .frame_busy   (frame_busy),
        .frame_sent   (frame_sent),
        .drop_count   (drop_count)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // uart_tx responder: done pulses done_dly edges after the start edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (uart.tx_start) begin
                cap_q.push_back(uart.tx_data);
                m_busy = 1'b1;
                repeat (done_dly - 1) @(posedge clk);
                #1;
                m_done = 1'b1;
                m_busy = 1'b0;
                @(posedge clk);
                #1;
                m_done = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (uart.tx_start) begin
                start_cnt++;
                if (prev_start) dbl_start++;
            end
            prev_start = uart.tx_start;
            if (frame_sent) sent_cnt++;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic send_sample(input logic [15:0] r, input logic [15:0] p,
                               input logic [15:0] y);
        @(negedge clk);
        roll = r;
        pitch = p;
        yaw = y;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        while (n < 2000) begin
            @(posedge clk);
            #1;
            if (frame_sent) break;
            n++;
        end
        check({tag, "_sent"}, 32'(frame_sent), 32'd1);
        check({tag, "_idle"}, 32'(frame_busy), 32'd0);
    endtask

    task automatic check_frame(input string tag, input logic [79:0] exp);
        logic [7:0] b;
        check({tag, "_len"}, 32'(cap_q.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            b = 8'h00;
            if (i < cap_q.size()) b = cap_q[i];
            check($sformatf("%s_b%0d", tag, i), 32'(b),
                  32'(exp[79 - 8 * i -: 8]));
        end
        cap_q.delete();
    endtask

    initial begin
        int s0;
        int s1;
        int n;
        rst_n = 1'b0;
        sample_valid = 1'b0;
        roll = 16'h0;
        pitch = 16'h0;
        yaw = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_start", 32'(uart.tx_start), 32'd0);
        check("rst_data", 32'(uart.tx_data), 32'h00);
        check("rst_busy", 32'(frame_busy), 32'd0);
        check("rst_sent", 32'(frame_sent), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        send_sample(16'h1234, 16'hABCD, 16'h00FF);
        check("f0_accept_busy", 32'(frame_busy), 32'd1);
        @(posedge clk);
        #1;
        check("f0_first_start", 32'(uart.tx_start), 32'd1);
        check("f0_first_data", 32'(uart.tx_data), 32'hDE);
        wait_frame("f0");
        check_frame("f0", 80'hDEAD_0012_34AB_CD00_FFBF);
        check("f0_drop", 32'(drop_count), 32'd0);
        check("f0_sent_cnt", 32'(sent_cnt), 32'd1);

        send_sample(16'h1234, 16'hABCD, 16'h00FF);
        wait_frame("f1");
        check_frame("f1", 80'hDEAD_0112_34AB_CD00_FFBE);

        send_sample(16'h1234, 16'hABCD, 16'h00FF);
        repeat (3) begin
            repeat (15) @(negedge clk);
            roll = 16'hFFFF;
            pitch = 16'h0000;
            yaw = 16'h5555;
            sample_valid = 1'b1;
            @(negedge clk);
            sample_valid = 1'b0;
        end
        wait_frame("f2");
        check_frame("f2", 80'hDEAD_0212_34AB_CD00_FFBD);
        check("f2_drop", 32'(drop_count), 32'd3);
        repeat (30) @(negedge clk);
        check("f2_no_extra_busy", 32'(frame_busy), 32'd0);
        check("f2_no_extra_bytes", 32'(cap_q.size()), 32'd0);
        check("f2_sent_cnt", 32'(sent_cnt), 32'd3);

        @(negedge clk);
        hold_busy = 1'b1;
        s0 = start_cnt;
        send_sample(16'h8001, 16'h7FFE, 16'h5A5A);
        roll = 16'h0BAD;
        sample_valid = 1'b1;
        repeat (300) @(negedge clk);
        sample_valid = 1'b0;
        check("bp_no_start", 32'(start_cnt), 32'(s0));
        check("bp_drop_sat", 32'(drop_count), 32'd255);
        check("bp_busy", 32'(frame_busy), 32'd1);
        hold_busy = 1'b0;
        @(posedge clk);
        #1;
        check("bp_start", 32'(uart.tx_start), 32'd1);
        check("bp_data", 32'(uart.tx_data), 32'hDE);
        wait_frame("f3");
        check_frame("f3", 80'hDEAD_0380_017F_FE5A_5A03);
        check("bp_start_cnt", 32'(start_cnt), 32'(s0 + 10));

        done_dly = 2;
        for (int i = 4; i <= 256; i++) begin
            send_sample(16'h0000, 16'h0000, 16'h0000);
            wait_frame("wrap");
            check("wrap_len", 32'(cap_q.size()), 32'd10);
            if (cap_q.size() == 10) begin
                check("wrap_seq", 32'(cap_q[2]), 32'(i & 255));
                check("wrap_chk", 32'(cap_q[9]), 32'(i & 255));
            end
            cap_q.delete();
        end
        done_dly = 20;

        s0 = sent_cnt;
        s1 = start_cnt;
        @(negedge clk);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        repeat (3) @(negedge clk);
        check("spur_idle_sent", 32'(sent_cnt), 32'(s0));
        check("spur_idle_start", 32'(start_cnt), 32'(s1));
        check("spur_idle_busy", 32'(frame_busy), 32'd0);

        hold_busy = 1'b1;
        send_sample(16'h0102, 16'h0304, 16'h0506);
        spur_done = 1'b1;
        repeat (3) @(negedge clk);
        spur_done = 1'b0;
        check("spur_send_sent", 32'(sent_cnt), 32'(s0));
        check("spur_send_busy", 32'(frame_busy), 32'd1);
        @(negedge clk);
        hold_busy = 1'b0;
        wait_frame("f_spur");
        check_frame("f_spur", 80'hDEAD_0101_0203_0405_0606);

        send_sample(16'h1234, 16'hABCD, 16'h00FF);
        n = 0;
        while (n < 2000) begin
            @(negedge clk);
            if (m_done && cap_q.size() == 5) break;
            n++;
        end
        check("rstmid_reached", 32'(cap_q.size()), 32'd5);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_start", 32'(uart.tx_start), 32'd0);
        check("rstmid_data", 32'(uart.tx_data), 32'h00);
        check("rstmid_busy", 32'(frame_busy), 32'd0);
        check("rstmid_sent", 32'(frame_sent), 32'd0);
        check("rstmid_drop", 32'(drop_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        cap_q.delete();
        send_sample(16'h1234, 16'hABCD, 16'h00FF);
        wait_frame("f_rst");
        check_frame("f_rst", 80'hDEAD_0012_34AB_CD00_FFBF);

        check("start_width", 32'(dbl_start), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
